excess3_to_binary: RTL and testbench
====================================

Name: excess3_to_binary

Overview:
- Registered excess-3 to binary decoder: converts one 4-bit excess-3 code per clock into its binary value (code minus 3).
- Flags codes that are not legal excess-3 representations of a BCD digit (0..9).
- Keeps a saturating count of illegal codes seen.
- Sits on the digit path after excess-3 sources (e.g. excess-3 adders/encoders) and feeds binary/BCD consumers.

Parameters:
- CHECK_RANGE, 1: 1 = flag codes outside 0011..1100 as errors; 0 = never assert err and never count errors.
- CNT_W, 8: width of the saturating error counter.

Ports:
- clk, input, 1: single system clock, rising-edge active.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: inp is sampled on this rising edge when high.
- inp, input, 4: excess-3 code.
- cnt_clr, input, 1: synchronous clear of err_count.
- op, output, 4: binary result, registered.
- out_valid, output, 1: op/err are valid this cycle.
- err, output, 1: the sampled code was illegal (inp < 3 or inp > 12).
- err_count, output, CNT_W: saturating count of illegal codes accepted.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect without a clock edge):
  - op = 0, out_valid = 0, err = 0, err_count = 0.
  - State is held while rst_n is low.
  - First capture occurs on the first rising edge after rst_n goes high.
- Latency: 1 cycle. A code accepted on edge N appears on op/out_valid/err after edge N.
- Arithmetic: op = (inp - 3) mod 16, i.e. 4-bit wrap-around subtraction. This is computed for every code, including illegal ones:
  - 0000 -> 1101, 0001 -> 1110, 0010 -> 1111.
  - 0011 -> 0000, 0100 -> 0001, ..., 1100 -> 1001.
  - 1101 -> 1010, 1110 -> 1011, 1111 -> 1100.
- Error flag: err = CHECK_RANGE and (inp < 3 or inp > 12), registered with op.
- in_valid low on an edge:
  - out_valid = 0 after that edge.
  - op and err hold their previous values.
  - err_count is unchanged.
- Continuous streaming: back-to-back in_valid gives one result per cycle. No backpressure, no handshake beyond in_valid.
- err_count:
  - Increments by 1 on an edge where in_valid = 1 and the code is illegal (and CHECK_RANGE = 1).
  - Saturates at 2^CNT_W - 1 and does not wrap.
- cnt_clr:
  - When high on an edge, err_count becomes 0 and cnt_clr takes priority over increment.
  - If cnt_clr coincides with an illegal code, err_count = 0 and err = 1 for that result.
  - cnt_clr does not affect op, err or out_valid.
- Reset mid-stream: any in-flight result is discarded (out_valid forced 0 immediately). No spurious output after release.
- No combinational path from inp to any output.

Test Plan:
- Sweep inp = 0..15 with in_valid = 1, one code per cycle. Expected one cycle later:
  - op = 13, 14, 15, 0, 1, ..., 9, 10, 11, 12.
  - err = 1 for inp in {0, 1, 2, 13, 14, 15}, else 0.
  - err_count ends at 6.
- Legal boundary values:
  - inp = 3 -> op = 0, err = 0.
  - inp = 12 -> op = 9, err = 0.
  - inp = 7 -> op = 4.
- Gap handling: inp = 8 valid, then in_valid = 0 for 2 cycles with inp = 0 -> op stays 5, out_valid = 0, err = 0, err_count unchanged.
- Saturation: with CNT_W = 2, feed 5 illegal codes (inp = 15) -> err_count = 3. Then cnt_clr = 1 together with inp = 0 -> err_count = 0, op = 13, err = 1.
- Async reset: assert rst_n low between clock edges while streaming -> op = 0, out_valid = 0, err_count = 0 immediately. After release, the first code inp = 9 gives op = 6 one cycle later.
- CHECK_RANGE = 0: inp = 14 -> op = 11, err = 0, err_count stays 0.

Source files
------------

// File: rtl/excess3_to_binary.sv
// Registered excess-3 to binary decoder with illegal-code flag
// and a saturating, clearable error counter.
module excess3_to_binary #(
  parameter bit CHECK_RANGE = 1'b1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       inp,
  input  logic             cnt_clr,
  output logic [3:0]       op,
  output logic             out_valid,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  logic [3:0]       op_d, op_q;
  logic             vld_d, vld_q;
  logic             err_d, err_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             illegal;

  always_comb begin
    illegal = CHECK_RANGE && ((inp < 4'd3) || (inp > 4'd12));
    op_d    = op_q;
    err_d   = err_q;
    vld_d   = in_valid;
    cnt_d   = cnt_q;
    if (in_valid) begin
      // wraps mod 16, so codes 0..2 land on 13..15
      op_d  = inp - 4'd3;
      err_d = illegal;
    end
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (in_valid && illegal && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      op_q  <= op_d;
      vld_q <= vld_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign op        = op_q;
  assign out_valid = vld_q;
  assign err       = err_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_excess3_to_binary.sv
// Bench for excess3_to_binary: default, narrow-counter and
// no-range-check instances checked against an arithmetic model.
module tb_excess3_to_binary;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] inp = 4'd0;
  logic       cnt_clr = 1'b0;

  logic [3:0] op0, op1, op2;
  logic       v0, v1, v2;
  logic       e0, e1, e2;
  logic [7:0] c0, c2;
  logic [1:0] c1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  excess3_to_binary dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inp(inp),
    .cnt_clr(cnt_clr), .op(op0), .out_valid(v0), .err(e0),
    .err_count(c0)
  );

  excess3_to_binary #(.CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inp(inp),
    .cnt_clr(cnt_clr), .op(op1), .out_valid(v1), .err(e1),
    .err_count(c1)
  );

  excess3_to_binary #(.CHECK_RANGE(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inp(inp),
    .cnt_clr(cnt_clr), .op(op2), .out_valid(v2), .err(e2),
    .err_count(c2)
  );

  // model: index 0 default, 1 two-bit counter, 2 no range check
  int m_op [3];
  int m_vld[3];
  int m_err[3];
  int m_cnt[3];
  int m_max[3] = '{255, 3, 255};
  int m_chk[3] = '{1, 1, 0};

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_op[k] = 0; m_vld[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_op[k]  <= 0;
        m_vld[k] <= 0;
        m_err[k] <= 0;
        m_cnt[k] <= 0;
      end else begin
        int bad;
        bad = m_chk[k] * ((int'(inp) < 3 || int'(inp) > 12) ? 1 : 0);
        m_vld[k] <= int'(in_valid);
        if (in_valid) begin
          m_op[k]  <= (int'(inp) + 16 - 3) % 16;
          m_err[k] <= bad;
        end
        if (cnt_clr)
          m_cnt[k] <= 0;
        else if (in_valid && bad == 1 && m_cnt[k] < m_max[k])
          m_cnt[k] <= m_cnt[k] + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m0_op",  int'(op0), m_op[0]);
    chk("m0_vld", int'(v0),  m_vld[0]);
    chk("m0_err", int'(e0),  m_err[0]);
    chk("m0_cnt", int'(c0),  m_cnt[0]);
    chk("m1_op",  int'(op1), m_op[1]);
    chk("m1_vld", int'(v1),  m_vld[1]);
    chk("m1_err", int'(e1),  m_err[1]);
    chk("m1_cnt", int'(c1),  m_cnt[1]);
    chk("m2_op",  int'(op2), m_op[2]);
    chk("m2_vld", int'(v2),  m_vld[2]);
    chk("m2_err", int'(e2),  m_err[2]);
    chk("m2_cnt", int'(c2),  m_cnt[2]);
  end

  // outputs seen right after a step reflect the previous step
  task automatic step(input logic v, input int code, input logic clr);
    @(negedge clk);
    #1;
    in_valid = v;
    inp      = 4'(code);
    cnt_clr  = clr;
  endtask

  int exp_op [16] = '{13, 14, 15, 0, 1, 2, 3, 4,
                      5, 6, 7, 8, 9, 10, 11, 12};
  int exp_err[16] = '{1, 1, 1, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 1, 1, 1};

  initial begin
    #3;
    chk("rst_op",  int'(op0), 0);
    chk("rst_vld", int'(v0),  0);
    chk("rst_err", int'(e0),  0);
    chk("rst_cnt", int'(c0),  0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(1'b1, i, 1'b0);
      if (i > 0) begin
        chk("sweep_op",  int'(op0), exp_op[i-1]);
        chk("sweep_err", int'(e0),  exp_err[i-1]);
        chk("sweep_vld", int'(v0),  1);
      end
    end
    step(1'b0, 0, 1'b0);
    chk("sweep_op",  int'(op0), exp_op[15]);
    chk("sweep_err", int'(e0),  exp_err[15]);
    chk("sweep_cnt", int'(c0),  6);
    chk("sweep_cnt_sat2", int'(c1), 3);
    chk("sweep_cnt_nochk", int'(c2), 0);

    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);
    chk("clr_cnt", int'(c0), 0);

    step(1'b1, 3, 1'b0);
    step(1'b1, 12, 1'b0);
    chk("b3_op",  int'(op0), 0);
    chk("b3_err", int'(e0),  0);
    step(1'b1, 7, 1'b0);
    chk("b12_op",  int'(op0), 9);
    chk("b12_err", int'(e0),  0);
    step(1'b1, 8, 1'b0);
    chk("b7_op", int'(op0), 4);

    step(1'b0, 0, 1'b0);
    chk("gap_op0", int'(op0), 5);
    for (int g = 0; g < 2; g++) begin
      step(1'b0, 0, 1'b0);
      chk("gap_op",  int'(op0), 5);
      chk("gap_vld", int'(v0),  0);
      chk("gap_err", int'(e0),  0);
      chk("gap_cnt", int'(c0),  0);
    end

    repeat (5) step(1'b1, 15, 1'b0);
    step(1'b1, 0, 1'b1);
    chk("sat_cnt", int'(c1), 3);
    chk("sat_cnt8", int'(c0), 5);
    step(1'b1, 14, 1'b0);
    chk("clr_ill_cnt", int'(c1), 0);
    chk("clr_ill_op",  int'(op1), 13);
    chk("clr_ill_err", int'(e1), 1);
    step(1'b0, 0, 1'b0);
    chk("nochk_op",  int'(op2), 11);
    chk("nochk_err", int'(e2),  0);
    chk("nochk_cnt", int'(c2),  0);
    chk("chk_cnt14", int'(c0),  1);

    step(1'b1, 5, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_op",  int'(op0), 0);
    chk("arst_vld", int'(v0),  0);
    chk("arst_cnt", int'(c0),  0);
    chk("arst_err", int'(e0),  0);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    inp      = 4'd9;
    chk("rel_vld", int'(v0), 0);
    step(1'b0, 0, 1'b0);
    chk("rel_op",  int'(op0), 6);
    chk("rel_vld1", int'(v0), 1);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
